// File: rtl/modulo_bcd_if.sv
// Handshake and data bundle between the sign/magnitude source and the BCD converter.
// The master drives the operand and start request; the slave returns status and digits.
interface modulo_bcd_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic [WIDTH-1:0]    s;
    logic                com_sinal;
    logic                inicio;
    logic                ocupado;
    logic                pronto;
    logic                bitSinal;
    logic [4*DIGITS-1:0] bcd;
    logic                estouro;

    modport master (
        output s, com_sinal, inicio,
        input  ocupado, pronto, bitSinal, bcd, estouro
    );

    modport slave (
        input  s, com_sinal, inicio,
        output ocupado, pronto, bitSinal, bcd, estouro
    );
endinterface

// File: rtl/modulo_bcd.sv
// Sequential signed-magnitude to packed-BCD converter (shift-and-add-3, one bit per clock).
// Results, sign and overflow are registered and only change on the finishing cycle.
module modulo_bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    modulo_bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_mag;
    logic [4*DIGITS-1:0] r_dig;
    logic                r_sign;
    logic                r_ovf;

    logic                r_ocupado;
    logic                r_pronto;
    logic                r_bit_sinal;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_estouro;

    logic                w_sign_in;
    logic [WIDTH-1:0]    w_mag_in;
    logic [4*DIGITS-1:0] w_adj;

    // Two's complement negate in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
    assign w_sign_in = bus.com_sinal & bus.s[WIDTH-1];
    assign w_mag_in  = (bus.s ^ {WIDTH{w_sign_in}}) + WIDTH'(w_sign_in);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_dig[4*gi +: 4] >= 4'd5)
                                    ? r_dig[4*gi +: 4] + 4'd3
                                    : r_dig[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OCIOSO:  if (bus.inicio) w_state_next = DESLOCA;
            DESLOCA: if (r_cnt == CW'(1)) w_state_next = FIM;
            FIM:     w_state_next = OCIOSO;
            default: w_state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mag  <= '0;
            r_dig  <= '0;
            r_sign <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (bus.inicio) begin
                        r_cnt  <= CW'(WIDTH);
                        r_mag  <= w_mag_in;
                        r_dig  <= '0;
                        r_sign <= w_sign_in;
                        r_ovf  <= 1'b0;
                    end
                end
                DESLOCA: begin
                    // Adjusted digits and magnitude shift as one register; the top bit leaving is overflow.
                    r_dig <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_ovf <= r_ovf | w_adj[4*DIGITS-1];
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocupado   <= 1'b0;
            r_pronto    <= 1'b0;
            r_bit_sinal <= 1'b0;
            r_bcd       <= '0;
            r_estouro   <= 1'b0;
        end else begin
            // Busy covers the shift phase plus the cycle in which results are presented.
            r_ocupado <= (w_state_next != OCIOSO) || (r_state == FIM);
            r_pronto  <= (r_state == FIM);
            if (r_state == FIM) begin
                r_bcd       <= r_dig;
                r_bit_sinal <= r_sign;
                r_estouro   <= r_ovf;
            end
        end
    end

    assign bus.ocupado  = r_ocupado;
    assign bus.pronto   = r_pronto;
    assign bus.bitSinal = r_bit_sinal;
    assign bus.bcd      = r_bcd;
    assign bus.estouro  = r_estouro;
endmodule

// File: tb/tb_modulo_bcd.sv
// Directed bench for modulo_bcd: three parameterisations, a vector table and hand-written timing sequences.
module tb_modulo_bcd;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    modulo_bcd_if #(.WIDTH(6),  .DIGITS(2)) if0();
    modulo_bcd_if #(.WIDTH(6),  .DIGITS(1)) if1();
    modulo_bcd_if #(.WIDTH(16), .DIGITS(5)) if2();

    modulo_bcd #(.WIDTH(6),  .DIGITS(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    modulo_bcd #(.WIDTH(6),  .DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    modulo_bcd #(.WIDTH(16), .DIGITS(5)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int          d;
        logic [31:0] s;
        logic        sg;
        logic [39:0] bcd;
        logic        bs;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[14];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic [31:0] sv, input logic sg, input logic ini);
        case (d)
            0: begin if0.s = sv[5:0];  if0.com_sinal = sg; if0.inicio = ini; end
            1: begin if1.s = sv[5:0];  if1.com_sinal = sg; if1.inicio = ini; end
            default: begin if2.s = sv[15:0]; if2.com_sinal = sg; if2.inicio = ini; end
        endcase
    endtask

    task automatic get_out(input int d, output logic pr, output logic oc, output logic bs,
                           output logic ov, output logic [39:0] bc);
        case (d)
            0: begin pr = if0.pronto; oc = if0.ocupado; bs = if0.bitSinal; ov = if0.estouro; bc = 40'(if0.bcd); end
            1: begin pr = if1.pronto; oc = if1.ocupado; bs = if1.bitSinal; ov = if1.estouro; bc = 40'(if1.bcd); end
            default: begin pr = if2.pronto; oc = if2.ocupado; bs = if2.bitSinal; ov = if2.estouro; bc = 40'(if2.bcd); end
        endcase
    endtask

    // Start one conversion and wait (bounded) for pronto; lat is -1 if it never came.
    task automatic run_conv(input int d, input logic [31:0] sv, input logic sg, output int lat);
        logic pr, oc, bs, ov;
        logic [39:0] bc;
        @(negedge clk);
        set_in(d, sv, sg, 1'b1);
        @(posedge clk);
        #1 set_in(d, sv, sg, 1'b0);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            get_out(d, pr, oc, bs, ov, bc);
            if (pr) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        logic        pr, oc, bs, ov;
        logic [39:0] bc, bc_hit;
        logic        bs_hit;
        int          lat, npr, p1, p2;

        n_vec = 0;
        n_bad = 0;

        //           d  s             sg    bcd           bs    ov    lat
        vecs[0]  = '{0, 32'h20,       1'b1, 40'h32,       1'b1, 1'b0, 7};
        vecs[1]  = '{0, 32'h3F,       1'b1, 40'h01,       1'b1, 1'b0, 7};
        vecs[2]  = '{0, 32'h1F,       1'b1, 40'h31,       1'b0, 1'b0, 7};
        vecs[3]  = '{0, 32'h00,       1'b1, 40'h00,       1'b0, 1'b0, 7};
        vecs[4]  = '{0, 32'h3F,       1'b0, 40'h63,       1'b0, 1'b0, 7};
        vecs[5]  = '{0, 32'h00,       1'b0, 40'h00,       1'b0, 1'b0, 7};
        vecs[6]  = '{0, 32'h3B,       1'b1, 40'h05,       1'b1, 1'b0, 7};
        vecs[7]  = '{1, 32'h3F,       1'b0, 40'h3,        1'b0, 1'b1, 7};
        vecs[8]  = '{1, 32'h09,       1'b0, 40'h9,        1'b0, 1'b0, 7};
        vecs[9]  = '{1, 32'h0A,       1'b0, 40'h0,        1'b0, 1'b1, 7};
        vecs[10] = '{1, 32'h3F,       1'b1, 40'h1,        1'b1, 1'b0, 7};
        vecs[11] = '{2, 32'h8000,     1'b1, 40'h32768,    1'b1, 1'b0, 17};
        vecs[12] = '{2, 32'hFFFF,     1'b0, 40'h65535,    1'b0, 1'b0, 17};
        vecs[13] = '{2, 32'h7FFF,     1'b1, 40'h32767,    1'b0, 1'b0, 17};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) set_in(d, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            get_out(d, pr, oc, bs, ov, bc);
            chk($sformatf("reset_state_dut%0d", d), {pr, oc, bs, ov, bc}, 44'd0);
        end

        for (int i = 0; i < 14; i++) begin
            run_conv(vecs[i].d, vecs[i].s, vecs[i].sg, lat);
            get_out(vecs[i].d, pr, oc, bs, ov, bc);
            $display("vec %0d dut%0d s=%h sg=%0d -> lat=%0d bcd=%h bitSinal=%0d estouro=%0d",
                     i, vecs[i].d, vecs[i].s, vecs[i].sg, lat, bc, bs, ov);
            chk($sformatf("v%0d_latency", i), 40'(lat), 40'(vecs[i].lat));
            chk($sformatf("v%0d_bcd", i), bc, vecs[i].bcd);
            chk($sformatf("v%0d_bitSinal", i), 40'(bs), 40'(vecs[i].bs));
            chk($sformatf("v%0d_estouro", i), 40'(ov), 40'(vecs[i].ov));
            chk($sformatf("v%0d_busy_in_fim", i), 40'(oc), 40'd1);
            @(posedge clk);
            #1 get_out(vecs[i].d, pr, oc, bs, ov, bc);
            chk($sformatf("v%0d_pronto_one_cycle", i), 40'(pr), 40'd0);
            chk($sformatf("v%0d_busy_falls", i), 40'(oc), 40'd0);
            repeat (3) @(posedge clk);
            #1 get_out(vecs[i].d, pr, oc, bs, ov, bc);
            chk($sformatf("v%0d_bcd_hold", i), bc, vecs[i].bcd);
        end

        // -5 with a second start at edge 3 that must be ignored.
        @(negedge clk);
        set_in(0, 32'h3B, 1'b1, 1'b1);
        @(posedge clk);
        #1 set_in(0, 32'h3B, 1'b1, 1'b0);
        npr = 0; p1 = -1; bc_hit = '0; bs_hit = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) set_in(0, 32'd10, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            if (e == 3) set_in(0, 32'd10, 1'b1, 1'b0);
            get_out(0, pr, oc, bs, ov, bc);
            if (e == 1) chk("ign_busy_rise", 40'(oc), 40'd1);
            if (e == 8) chk("ign_busy_low", 40'(oc), 40'd0);
            if (pr) begin
                npr++;
                if (p1 < 0) begin p1 = e; bc_hit = bc; bs_hit = bs; end
            end
        end
        $display("ignored-start seq: prontos=%0d first=%0d bcd=%h bitSinal=%0d", npr, p1, bc_hit, bs_hit);
        chk("ign_pronto_count", 40'(npr), 40'd1);
        chk("ign_pronto_edge", 40'(p1), 40'd7);
        chk("ign_bcd", bc_hit, 40'h05);
        chk("ign_bitSinal", 40'(bs_hit), 40'd1);

        // inicio held high: back-to-back conversions every WIDTH+2 cycles.
        @(negedge clk);
        set_in(0, 32'd27, 1'b0, 1'b1);
        @(posedge clk);
        npr = 0; p1 = -1; p2 = -1;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (e == 15) set_in(0, 32'd27, 1'b0, 1'b0);
            get_out(0, pr, oc, bs, ov, bc);
            if (pr) begin
                npr++;
                if (p1 < 0) p1 = e; else p2 = e;
                chk($sformatf("held_bcd_e%0d", e), bc, 40'h27);
            end
        end
        $display("held-start seq: prontos=%0d at %0d and %0d", npr, p1, p2);
        chk("held_pronto_count", 40'(npr), 40'd2);
        chk("held_first_edge", 40'(p1), 40'd7);
        chk("held_second_edge", 40'(p2), 40'd15);
        repeat (2) @(posedge clk);
        #1 get_out(0, pr, oc, bs, ov, bc);
        chk("held_idle_after", 40'(oc), 40'd0);

        // Reset in the middle of a conversion of 27.
        @(negedge clk);
        set_in(0, 32'd27, 1'b0, 1'b1);
        @(posedge clk);
        #1 set_in(0, 32'd27, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 get_out(0, pr, oc, bs, ov, bc);
        $display("mid-conversion reset: pronto=%0d ocupado=%0d bcd=%h", pr, oc, bc);
        chk("midrst_outputs_zero", {pr, oc, bs, ov, bc}, 44'd0);
        @(negedge clk);
        rst = 1'b0;
        npr = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1 get_out(0, pr, oc, bs, ov, bc);
            if (pr || oc) npr++;
        end
        chk("midrst_no_pronto", 40'(npr), 40'd0);
        run_conv(0, 32'd27, 1'b0, lat);
        get_out(0, pr, oc, bs, ov, bc);
        $display("post-reset conversion: lat=%0d bcd=%h", lat, bc);
        chk("midrst_fresh_latency", 40'(lat), 40'd7);
        chk("midrst_fresh_bcd", bc, 40'h27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
